image_blitter: RTL and testbench



---
 rtl/whack_pkg.sv | 10 +
 rtl/blit_delay_line.sv | 15 +
 rtl/image_blitter.sv | 116 +++++++++++
 tb/tb_image_blitter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/whack_pkg.sv
// whack_pkg: screen/colour constants, default transparent key and blitter state type shared by the blitter files
package whack_pkg;
    localparam int COLOUR_W = 12;
    localparam int SCR_W = 160;
    localparam int SCR_H = 120;
    localparam int X_W = 8;
    localparam int Y_W = 8;
    localparam logic [COLOUR_W-1:0] KEY_COLOUR = 12'hF0F;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} blit_state_t;
endpackage

// File: rtl/blit_delay_line.sv
// blit_delay_line: DEPTH-stage shift register (clk, reset clears all stages, d in, q = d delayed DEPTH clocks)
module blit_delay_line #(
    parameter int DEPTH = 1,
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [DEPTH-1:0][W-1:0] sr_q, sr_d;
    always_comb sr_d = (DEPTH*W)'({sr_q, d});
    always_ff @(posedge clk) sr_q <= reset ? '0 : sr_d;
    assign q = sr_q[DEPTH-1];
endmodule

// File: rtl/image_blitter.sv
// image_blitter: reads a W*H ROM image and streams (x,y,colour,plot) at origin (start/x_org/y_org in; rom_addr/rom_q ROM side; x/y/colour/plot out; busy/done status); IMAGE_BLITTER_TRANSPARENT_EN skips KEY_COLOUR pixels
module image_blitter #(
    parameter int IMG_W = 160,
    parameter int IMG_H = 120,
    parameter int SCR_W = whack_pkg::SCR_W,
    parameter int SCR_H = whack_pkg::SCR_H,
    parameter int X_W = whack_pkg::X_W,
    parameter int Y_W = whack_pkg::Y_W,
    parameter int ADDR_W = 15,
    parameter int COLOUR_W = whack_pkg::COLOUR_W,
    parameter int ROM_LATENCY = 1
`ifdef IMAGE_BLITTER_TRANSPARENT_EN
    , parameter logic [COLOUR_W-1:0] KEY_COLOUR = whack_pkg::KEY_COLOUR
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [X_W-1:0]      x_org,
    input  logic [Y_W-1:0]      y_org,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [COLOUR_W-1:0] rom_q,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);
    import whack_pkg::*;
    localparam int N = IMG_W * IMG_H;
    blit_state_t state_q, state_d;
    logic [X_W-1:0] xo_q, xo_d, col_q, col_d, x_q, x_d, col_a;
    logic [Y_W-1:0] yo_q, yo_d, row_q, row_d, y_q, y_d, row_a;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic [1:0] cnt_q, cnt_d;
    logic plot_q, plot_d, v_a, go, step, last, wrap, hit;
    logic [X_W:0] xs;
    logic [Y_W:0] ys;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            xo_q <= '0;
            yo_q <= '0;
            col_q <= '0;
            row_q <= '0;
            addr_q <= '0;
            cnt_q <= '0;
            x_q <= '0;
            y_q <= '0;
            colour_q <= '0;
            plot_q <= 1'b0;
        end else begin
            state_q <= state_d;
            xo_q <= xo_d;
            yo_q <= yo_d;
            col_q <= col_d;
            row_q <= row_d;
            addr_q <= addr_d;
            cnt_q <= cnt_d;
            x_q <= x_d;
            y_q <= y_d;
            colour_q <= colour_d;
            plot_q <= plot_d;
        end
    end
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: state_d = start ? RUN : IDLE;
            RUN: state_d = last ? DRAIN : RUN;
            DRAIN: state_d = cnt_q == 2'(ROM_LATENCY) ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
    end
    // {valid, col, row} travel alongside the ROM read so they meet rom_q
    blit_delay_line #(.DEPTH(ROM_LATENCY), .W(1 + X_W + Y_W)) u_dl (
        .clk(clk),
        .reset(reset),
        .d({state_q == RUN, col_q, row_q}),
        .q({v_a, col_a, row_a})
    );
    always_comb begin
        go = state_q == IDLE && start;
        last = addr_q == ADDR_W'(N - 1);
        step = state_q == RUN && !last;
        wrap = col_q == X_W'(IMG_W - 1);
        xo_d = go ? x_org : xo_q;
        yo_d = go ? y_org : yo_q;
        col_d = go || (step && wrap) ? '0 : step ? col_q + 1'b1 : col_q;
        row_d = go ? '0 : step && wrap ? row_q + 1'b1 : row_q;
        addr_d = go ? '0 : step ? addr_q + 1'b1 : addr_q;
        cnt_d = state_q == DRAIN ? cnt_q + 1'b1 : '0;
        // one extra bit so origin+offset past the screen edge is clipped, not wrapped
        xs = {1'b0, xo_q} + {1'b0, col_a};
        ys = {1'b0, yo_q} + {1'b0, row_a};
        hit = v_a && xs < (X_W + 1)'(SCR_W) && ys < (Y_W + 1)'(SCR_H);
`ifdef IMAGE_BLITTER_TRANSPARENT_EN
        hit = hit && rom_q != KEY_COLOUR;
`endif
        plot_d = hit;
        x_d = hit ? xs[X_W-1:0] : x_q;
        y_d = hit ? ys[Y_W-1:0] : y_q;
        colour_d = hit ? rom_q : colour_q;
    end
    always_comb begin
        rom_addr = addr_q;
        x = x_q;
        y = y_q;
        colour = colour_q;
        plot = plot_q;
        busy = state_q == RUN || state_q == DRAIN;
        done = state_q == DONE;
    end
endmodule

// File: tb/tb_image_blitter.sv
// tb_image_blitter: two 4x3 blitters (ROM latency 1 and 2) checked against a cycle-index model plus literal expectations
module tb_image_blitter;
`ifdef IMAGE_BLITTER_TRANSPARENT_EN
    localparam int TR = 1;
`else
    localparam int TR = 0;
`endif
    localparam int IW = 4;
    localparam int N = 12;
    logic clk = 0, rst = 1, start = 0;
    logic [7:0] xorg = 0, yorg = 0;
    logic [14:0] da[2];
    logic [11:0] dq[2], dc[2], qd;
    logic [7:0] dx[2], dy[2];
    logic dp[2], db[2], dd[2];
    bit armed = 0;
    int checks = 0, errors = 0;
    int ms[2] = '{-1, -1};
    int ox[2] = '{0, 0};
    int oy[2] = '{0, 0};
    int e_x[2] = '{0, 0};
    int e_y[2] = '{0, 0};
    int e_c[2] = '{0, 0};
    int e_a[2] = '{0, 0};
    bit e_p[2], e_b[2], e_d[2], e_ac[2];
    int plots[2], dones[2], first[2], donec[2];
    always #5 clk = ~clk;
    image_blitter #(.IMG_W(4), .IMG_H(3), .ROM_LATENCY(1)
`ifdef IMAGE_BLITTER_TRANSPARENT_EN
        , .KEY_COLOUR(12'd5)
`endif
    ) u1 (.clk(clk), .reset(rst), .start(start), .x_org(xorg), .y_org(yorg), .rom_addr(da[0]),
          .rom_q(dq[0]), .x(dx[0]), .y(dy[0]), .colour(dc[0]), .plot(dp[0]), .busy(db[0]), .done(dd[0]));
    image_blitter #(.IMG_W(4), .IMG_H(3), .ROM_LATENCY(2)
`ifdef IMAGE_BLITTER_TRANSPARENT_EN
        , .KEY_COLOUR(12'd5)
`endif
    ) u2 (.clk(clk), .reset(rst), .start(start), .x_org(xorg), .y_org(yorg), .rom_addr(da[1]),
          .rom_q(dq[1]), .x(dx[1]), .y(dy[1]), .colour(dc[1]), .plot(dp[1]), .busy(db[1]), .done(dd[1]));
    always @(posedge clk) begin
        dq[0] <= 12'(da[0]);
        qd <= 12'(da[1]);
        dq[1] <= qd;
    end
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int m, p, px, py, ax, ay;
            bit pl;
            ax = ox[d];
            ay = oy[d];
            if (rst) m = -1;
            else if (ms[d] < 0) begin
                m = start ? 1 : -1;
                if (start) begin
                    ax = xorg;
                    ay = yorg;
                end
            end else m = ms[d] >= N + d + 3 ? -1 : ms[d] + 1;
            p = m - (d + 3);
            px = ax + p % IW;
            py = ay + p / IW;
            pl = m > 0 && p >= 0 && p < N && px < 160 && py < 120 && !(TR == 1 && p == 5);
            ms[d] <= m;
            ox[d] <= ax;
            oy[d] <= ay;
            e_p[d] <= pl;
            e_b[d] <= m >= 1 && m <= N + d + 2;
            e_d[d] <= m == N + d + 3;
            e_ac[d] <= m >= 1 && m <= N;
            e_a[d] <= m - 1;
            e_x[d] <= rst ? 0 : pl ? px : e_x[d];
            e_y[d] <= rst ? 0 : pl ? py : e_y[d];
            e_c[d] <= rst ? 0 : pl ? p : e_c[d];
        end
    end
    task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0d want %0d at t=%0t", nm, d, act, exp, $time);
        end
    endtask
    always @(negedge clk) begin
        if (armed) begin
            for (int d = 0; d < 2; d++) begin
                chk("plot", d, 32'(dp[d]), 32'(e_p[d]));
                chk("busy", d, 32'(db[d]), 32'(e_b[d]));
                chk("done", d, 32'(dd[d]), 32'(e_d[d]));
                chk("x", d, 32'(dx[d]), e_x[d]);
                chk("y", d, 32'(dy[d]), e_y[d]);
                chk("colour", d, 32'(dc[d]), e_c[d]);
                if (e_ac[d]) chk("rom_addr", d, 32'(da[d]), e_a[d]);
                if (ms[d] == 1) begin
                    plots[d] = 0;
                    dones[d] = 0;
                    first[d] = -1;
                    donec[d] = -1;
                end
                if (dp[d] === 1'b1) begin
                    plots[d]++;
                    if (first[d] < 0) first[d] = ms[d];
                end
                if (dd[d] === 1'b1) begin
                    dones[d]++;
                    donec[d] = ms[d];
                end
            end
        end
    end
    task automatic pulse();
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
    endtask
    initial begin
        repeat (3) @(negedge clk);
        start = 1;
        @(negedge clk);
        rst = 0;
        start = 0;
        armed = 1;
        repeat (3) @(negedge clk);
        pulse();
        repeat (20) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("basic_plots", d, plots[d], N - TR);
            chk("basic_first", d, first[d], 3 + d);
            chk("basic_done_cycle", d, donec[d], 15 + d);
            chk("basic_dones", d, dones[d], 1);
            chk("basic_last_x", d, 32'(dx[d]), 3);
            chk("basic_last_y", d, 32'(dy[d]), 2);
            chk("basic_last_colour", d, 32'(dc[d]), 11);
        end
        xorg = 158;
        yorg = 118;
        pulse();
        repeat (20) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("clip_plots", d, plots[d], 4 - TR);
            chk("clip_done_cycle", d, donec[d], 15 + d);
            chk("clip_dones", d, dones[d], 1);
        end
        xorg = 0;
        yorg = 0;
        pulse();
        repeat (5) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        repeat (20) @(negedge clk);
        for (int d = 0; d < 2; d++) chk("reset_no_done", d, dones[d], 0);
        pulse();
        repeat (20) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("redraw_plots", d, plots[d], N - TR);
            chk("redraw_dones", d, dones[d], 1);
        end
        xorg = 10;
        yorg = 20;
        pulse();
        repeat (3) @(negedge clk);
        start = 1;
        xorg = 90;
        @(negedge clk);
        start = 0;
        repeat (9) @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (20) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("busy_plots", d, plots[d], N - TR);
            chk("busy_dones", d, dones[d], 1);
            chk("busy_last_x", d, 32'(dx[d]), 13);
            chk("busy_last_y", d, 32'(dy[d]), 22);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
